// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter sharing the vga_adapter pixel-write port between drawing engines.
// Supports ownership locking for atomic sprite draws and drops transparent pixels.
module vga_plot_arbiter #(
    parameter int unsigned NUM_REQ      = 3,
    parameter logic [8:0]  TRANSPARENT  = 9'h1FF,
    parameter int unsigned LOCK_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   req_lock,
    input  logic [NUM_REQ*8-1:0] req_x,
    input  logic [NUM_REQ*7-1:0] req_y,
    input  logic [NUM_REQ*9-1:0] req_colour,
    output logic [NUM_REQ-1:0]   ack,
    output logic [2:0]           owner,
    output logic                 locked,
    output logic [7:0]           vga_x,
    output logic [6:0]           vga_y,
    output logic [8:0]           vga_colour,
    output logic                 vga_plot
);

    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned X_W   = 8;
    localparam int unsigned Y_W   = 7;
    localparam int unsigned C_W   = 9;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] owner_q;
    logic [IDX_W-1:0] owner_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic [NUM_REQ-1:0] owner_oh;
    logic               hi_found;
    logic               lo_found;
    logic [IDX_W-1:0]   hi_idx;
    logic [IDX_W-1:0]   lo_idx;

    logic               grant_valid;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_lock;
    logic [X_W-1:0]     grant_x;
    logic [Y_W-1:0]     grant_y;
    logic [C_W-1:0]     grant_colour;
    logic               owner_req;
    logic               owner_lock;

    // Rotated priority: first request above the owner wins, else first at/below it.
    always_comb begin
        owner_oh = '0;
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            owner_oh[i] = (owner_q == IDX_W'(i));
            if (req[i] && !hi_found && (IDX_W'(i) > owner_q)) begin
                hi_found = 1'b1;
                hi_idx   = IDX_W'(i);
            end
            if (req[i] && !lo_found && (IDX_W'(i) <= owner_q)) begin
                lo_found = 1'b1;
                lo_idx   = IDX_W'(i);
            end
        end
    end

    assign owner_req  = |(req & owner_oh);
    assign owner_lock = |(req_lock & owner_oh);

    // Grant / ack decode; reset suppresses any acceptance in the same cycle.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = owner_q;
        ack         = '0;
        if (!reset) begin
            case (state_q)
                ST_IDLE: begin
                    grant_valid = hi_found | lo_found;
                    grant_idx   = hi_found ? hi_idx : lo_idx;
                end
                ST_LOCKED: begin
                    grant_valid = owner_req;
                    grant_idx   = owner_q;
                end
                default: begin
                    grant_valid = 1'b0;
                end
            endcase
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            ack[i] = grant_valid && (grant_idx == IDX_W'(i));
        end
    end

    // Winner's payload mux
    always_comb begin
        grant_lock   = 1'b0;
        grant_x      = '0;
        grant_y      = '0;
        grant_colour = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                grant_lock   = req_lock[i];
                grant_x      = req_x[X_W*i +: X_W];
                grant_y      = req_y[Y_W*i +: Y_W];
                grant_colour = req_colour[C_W*i +: C_W];
            end
        end
    end

    // Next-state: ownership, lock hold and idle timeout
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (grant_valid) begin
                    owner_d = grant_idx;
                    if (grant_lock) begin
                        state_d = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (owner_req) begin
                    cnt_d = '0;
                    if (!owner_lock) begin
                        state_d = ST_IDLE;
                    end
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= IDX_W'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    // Pixel output stage: one cycle behind acceptance, coordinates hold when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
        end else begin
            vga_plot <= grant_valid && (grant_colour != TRANSPARENT);
            if (grant_valid) begin
                vga_x      <= grant_x;
                vga_y      <= grant_y;
                vga_colour <= grant_colour;
            end
        end
    end

    assign owner  = owner_q;
    assign locked = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Self-checking bench for vga_plot_arbiter: directed scenarios plus a
// scoreboarded random stress run against a behavioural arbitration model.
module tb_vga_plot_arbiter;

    localparam int unsigned NR = 3;
    localparam int unsigned LT = 4;
    localparam logic [8:0]  TR = 9'h1FF;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [8:0] c;
        logic       p;
    } pix_t;

    logic          clk;
    logic          reset;
    logic [NR-1:0] req;
    logic [NR-1:0] req_lock;
    logic [NR*8-1:0] req_x;
    logic [NR*7-1:0] req_y;
    logic [NR*9-1:0] req_colour;
    logic [NR-1:0] ack;
    logic [2:0]    owner;
    logic          locked;
    logic [7:0]    vga_x;
    logic [6:0]    vga_y;
    logic [8:0]    vga_colour;
    logic          vga_plot;

    int n_tests = 0;
    int n_fail  = 0;
    pix_t sb_q[$];

    vga_plot_arbiter #(.NUM_REQ(NR), .TRANSPARENT(TR), .LOCK_TIMEOUT(LT)) dut (
        .clk(clk), .reset(reset), .req(req), .req_lock(req_lock),
        .req_x(req_x), .req_y(req_y), .req_colour(req_colour),
        .ack(ack), .owner(owner), .locked(locked),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input int i, input logic [7:0] x, input logic [6:0] y, input logic [8:0] c);
        req_x[8*i +: 8]      = x;
        req_y[7*i +: 7]      = y;
        req_colour[9*i +: 9] = c;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        req      = '0;
        req_lock = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        req      = '0;
        req_lock = '0;
        tick();
        req = 3'b111;
        @(negedge clk);
        n_tests++; if (ack !== 3'b000) begin n_fail++; $display("FAIL reset_ack got %b exp 000", ack); end
        n_tests++; if (owner !== 3'd2) begin n_fail++; $display("FAIL reset_owner got %0d exp 2", owner); end
        n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got %b exp 0", locked); end
        n_tests++; if ({vga_x, vga_y, vga_colour, vga_plot} !== 25'd0) begin
            n_fail++; $display("FAIL reset_vga got x=%0d y=%0d c=%h p=%b exp all 0", vga_x, vga_y, vga_colour, vga_plot);
        end
        tick();
        reset = 1'b0;
        req   = '0;
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] exp_ack;
        do_reset();
        for (int i = 0; i < NR; i++) set_pix(i, 8'(10 + i), 7'(20 + i), 9'(1 + i));
        req      = 3'b111;
        req_lock = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            exp_ack = NR'(1 << (k % 3));
            n_tests++; if (ack !== exp_ack) begin n_fail++; $display("FAIL rr_ack[%0d] got %b exp %b", k, ack, exp_ack); end
            if (k > 0) begin
                n_tests++; if (vga_plot !== 1'b1 || vga_x !== 8'(10 + (k - 1) % 3)) begin
                    n_fail++; $display("FAIL rr_vga[%0d] got p=%b x=%0d exp p=1 x=%0d", k, vga_plot, vga_x, 10 + (k - 1) % 3);
                end
            end else begin
                n_tests++; if (vga_plot !== 1'b0) begin n_fail++; $display("FAIL rr_vga0 got p=%b exp 0", vga_plot); end
            end
            tick();
        end
        req = '0;
        @(negedge clk);
        n_tests++; if (ack !== 3'b000 || vga_plot !== 1'b1 || vga_x !== 8'd12 || vga_colour !== 9'd3) begin
            n_fail++; $display("FAIL rr_last got ack=%b p=%b x=%0d c=%0d exp ack=000 p=1 x=12 c=3", ack, vga_plot, vga_x, vga_colour);
        end
        tick();
        @(negedge clk);
        n_tests++; if (vga_plot !== 1'b0 || vga_x !== 8'd12) begin
            n_fail++; $display("FAIL rr_hold got p=%b x=%0d exp p=0 x=12", vga_plot, vga_x);
        end
    endtask

    task automatic test_lock_burst();
        logic [3:0] lock_seq;
        lock_seq = 4'b0111;
        do_reset();
        set_pix(0, 8'd40, 7'd41, 9'h0AA);
        set_pix(1, 8'd50, 7'd51, 9'h055);
        req = 3'b011;
        for (int k = 0; k < 4; k++) begin
            req_lock = {2'b00, lock_seq[k]};
            @(negedge clk);
            n_tests++; if (ack !== 3'b001) begin n_fail++; $display("FAIL burst_ack[%0d] got %b exp 001", k, ack); end
            n_tests++; if (locked !== (k >= 1)) begin n_fail++; $display("FAIL burst_locked[%0d] got %b exp %b", k, locked, k >= 1); end
            tick();
        end
        req      = 3'b010;
        req_lock = '0;
        @(negedge clk);
        n_tests++; if (ack !== 3'b010 || locked !== 1'b0 || vga_x !== 8'd40) begin
            n_fail++; $display("FAIL burst_release got ack=%b locked=%b x=%0d exp ack=010 locked=0 x=40", ack, locked, vga_x);
        end
        tick();
        req = '0;
        @(negedge clk);
        n_tests++; if (vga_x !== 8'd50 || vga_plot !== 1'b1 || owner !== 3'd1) begin
            n_fail++; $display("FAIL burst_after got x=%0d p=%b owner=%0d exp x=50 p=1 owner=1", vga_x, vga_plot, owner);
        end
    endtask

    task automatic test_transparent();
        do_reset();
        set_pix(2, 8'd159, 7'd119, TR);
        req = 3'b100;
        @(negedge clk);
        n_tests++; if (ack !== 3'b100) begin n_fail++; $display("FAIL transp_ack got %b exp 100", ack); end
        tick();
        req = '0;
        @(negedge clk);
        n_tests++; if (vga_plot !== 1'b0 || vga_x !== 8'd159 || vga_y !== 7'd119 || vga_colour !== TR) begin
            n_fail++; $display("FAIL transp_vga got p=%b x=%0d y=%0d c=%h exp p=0 x=159 y=119 c=1ff", vga_plot, vga_x, vga_y, vga_colour);
        end
        n_tests++; if (owner !== 3'd2 || locked !== 1'b0) begin
            n_fail++; $display("FAIL transp_owner got owner=%0d locked=%b exp 2 0", owner, locked);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        set_pix(1, 8'd3, 7'd4, 9'h010);
        req      = 3'b010;
        req_lock = 3'b010;
        @(negedge clk);
        n_tests++; if (ack !== 3'b010) begin n_fail++; $display("FAIL tmo_first got %b exp 010", ack); end
        tick();
        set_pix(0, 8'd7, 7'd8, 9'h00F);
        req      = 3'b001;
        req_lock = '0;
        for (int k = 0; k < int'(LT); k++) begin
            @(negedge clk);
            n_tests++; if (ack !== 3'b000 || locked !== 1'b1) begin
                n_fail++; $display("FAIL tmo_wait[%0d] got ack=%b locked=%b exp ack=000 locked=1", k, ack, locked);
            end
            tick();
        end
        @(negedge clk);
        n_tests++; if (ack !== 3'b001 || locked !== 1'b0 || owner !== 3'd1) begin
            n_fail++; $display("FAIL tmo_release got ack=%b locked=%b owner=%0d exp 001 0 1", ack, locked, owner);
        end
        tick();
        req = '0;
        @(negedge clk);
        n_tests++; if (owner !== 3'd0 || vga_x !== 8'd7 || vga_plot !== 1'b1) begin
            n_fail++; $display("FAIL tmo_after got owner=%0d x=%0d p=%b exp 0 7 1", owner, vga_x, vga_plot);
        end
    endtask

    task automatic test_reset_locked();
        do_reset();
        set_pix(0, 8'd1, 7'd2, 9'h033);
        req      = 3'b001;
        req_lock = 3'b001;
        @(negedge clk);
        n_tests++; if (ack !== 3'b001) begin n_fail++; $display("FAIL rstlk_grant got %b exp 001", ack); end
        tick();
        reset = 1'b1;
        @(negedge clk);
        n_tests++; if (ack !== 3'b000 || locked !== 1'b1) begin
            n_fail++; $display("FAIL rstlk_during got ack=%b locked=%b exp 000 1", ack, locked);
        end
        tick();
        reset    = 1'b0;
        req      = '0;
        req_lock = '0;
        @(negedge clk);
        n_tests++; if (locked !== 1'b0 || vga_plot !== 1'b0 || owner !== 3'd2 || ack !== 3'b000) begin
            n_fail++; $display("FAIL rstlk_after got locked=%b p=%b owner=%0d ack=%b exp 0 0 2 000", locked, vga_plot, owner, ack);
        end
    endtask

    task automatic test_stress();
        logic [NR-1:0] e_ack;
        int   g;
        int   cand;
        bit   m_locked;
        int   m_owner;
        int   m_cnt;
        int   wait_cnt[NR];
        pix_t exp_pix;
        pix_t new_pix;
        do_reset();
        m_locked = 1'b0;
        m_owner  = NR - 1;
        m_cnt    = 0;
        e_ack    = '0;
        sb_q.delete();
        for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < NR; i++) begin
                if (req[i] && !e_ack[i]) begin
                    if ($urandom_range(19) == 0) req[i] = 1'b0;
                end else begin
                    req[i]      = ($urandom_range(9) < 6);
                    req_lock[i] = ($urandom_range(9) < 3);
                    set_pix(i, 8'($urandom_range(159)), 7'($urandom_range(119)),
                            ($urandom_range(7) == 0) ? TR : 9'($urandom_range(510)));
                end
            end
            reset = ($urandom_range(499) == 0);
            @(negedge clk);

            e_ack = '0;
            g     = -1;
            if (!reset) begin
                if (!m_locked) begin
                    for (int k = 1; k <= NR; k++) begin
                        cand = (m_owner + k) % NR;
                        if (g < 0 && req[cand]) g = cand;
                    end
                end else if (req[m_owner]) begin
                    g = m_owner;
                end
            end
            if (g >= 0) e_ack[g] = 1'b1;

            n_tests++; if (ack !== e_ack) begin n_fail++; $display("FAIL stress_ack c%0d got %b exp %b", cyc, ack, e_ack); end
            n_tests++; if (!$onehot0(ack)) begin n_fail++; $display("FAIL stress_onehot c%0d got %b exp one-hot", cyc, ack); end
            n_tests++; if (owner !== 3'(m_owner) || locked !== m_locked) begin
                n_fail++; $display("FAIL stress_state c%0d got owner=%0d locked=%b exp %0d %b", cyc, owner, locked, m_owner, m_locked);
            end
            if (sb_q.size() > 0) begin
                exp_pix = sb_q.pop_front();
                n_tests++; if ({vga_x, vga_y, vga_colour, vga_plot} !== exp_pix) begin
                    n_fail++; $display("FAIL stress_pix c%0d got x=%0d y=%0d c=%h p=%b exp x=%0d y=%0d c=%h p=%b",
                                       cyc, vga_x, vga_y, vga_colour, vga_plot, exp_pix.x, exp_pix.y, exp_pix.c, exp_pix.p);
                end
            end else begin
                n_tests++; if (vga_plot !== 1'b0) begin n_fail++; $display("FAIL stress_noplot c%0d got p=%b exp 0", cyc, vga_plot); end
            end

            if (reset) begin
                m_locked = 1'b0;
                m_owner  = NR - 1;
                m_cnt    = 0;
                for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
            end else begin
                if (g >= 0) begin
                    n_tests++; if (wait_cnt[g] > NR - 1) begin
                        n_fail++; $display("FAIL stress_starve c%0d req%0d waited %0d grants exp <= %0d", cyc, g, wait_cnt[g], NR - 1);
                    end
                    for (int i = 0; i < NR; i++) begin
                        if (!req[i] || i == g) wait_cnt[i] = 0;
                        else if (!m_locked) wait_cnt[i]++;
                    end
                    new_pix.x = req_x[8*g +: 8];
                    new_pix.y = req_y[7*g +: 7];
                    new_pix.c = req_colour[9*g +: 9];
                    new_pix.p = (new_pix.c != TR);
                    sb_q.push_back(new_pix);
                    if (!m_locked) begin
                        m_owner  = g;
                        m_locked = req_lock[g];
                    end else begin
                        m_cnt = 0;
                        if (!req_lock[g]) m_locked = 1'b0;
                    end
                end else begin
                    for (int i = 0; i < NR; i++) if (!req[i]) wait_cnt[i] = 0;
                    if (m_locked) begin
                        if (m_cnt == int'(LT) - 1) begin
                            m_locked = 1'b0;
                            m_cnt    = 0;
                        end else begin
                            m_cnt++;
                        end
                    end
                end
            end
            tick();
        end
        reset = 1'b0;
        req   = '0;
    endtask

    initial begin
        reset      = 1'b1;
        req        = '0;
        req_lock   = '0;
        req_x      = '0;
        req_y      = '0;
        req_colour = '0;
        test_reset();
        test_round_robin();
        test_lock_burst();
        test_transparent();
        test_timeout();
        test_reset_locked();
        test_stress();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
